// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared constants and helpers for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int WORD = 32;
  localparam int MAX_BURST_DEF = 4;
  localparam int REQ_FETCH = 0;
  localparam int REQ_WB = 1;
  localparam int REQ_LOAD = 2;
  function automatic int clamp_len(int len, int max_len);
    return len == 0 ? 1 : (len > max_len ? max_len : len);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker starting after rr_ptr
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IW-1:0]   gnt_idx
);
  logic [IW-1:0] j;
  // scan farthest-to-nearest so the nearest requester after rr_ptr wins last
  always_comb begin
    gnt_onehot = '0;
    gnt_idx = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (req[j]) begin
        gnt_onehot = '0;
        gnt_onehot[j] = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one synchronous-read memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW = WORD,
  parameter int DW = WORD,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BLW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_wdata,
  input  logic [NREQ*BLW-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic              rlast,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [IW-1:0] owner, rr_ptr, pick_idx;
  logic [NREQ-1:0] pick;
  logic [BW-1:0] beats_left;
  logic free;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(req),
    .rr_ptr(rr_ptr),
    .gnt_onehot(pick),
    .gnt_idx(pick_idx)
  );
  assign free = !mem_en || beats_left == BW'(1);
  assign gnt = (free && !rst) ? pick : '0;
  assign rdata = mem_rdata;
  assign busy = mem_en || |rvalid;
  // sequencer: accept a grant, step a read burst, or go idle; read returns lag the bus by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      beats_left <= '0;
      owner <= '0;
      rr_ptr <= IW'(NREQ - 1);
      rvalid <= '0;
      rlast <= 1'b0;
    end else begin
      rvalid <= (mem_en && !mem_we) ? NREQ'(1) << owner : '0;
      rlast <= mem_en && !mem_we && beats_left == BW'(1);
      if (|gnt) begin
        mem_en <= 1'b1;
        mem_we <= req_we[pick_idx];
        mem_addr <= req_addr[int'(pick_idx)*AW +: AW];
        mem_wdata <= req_wdata[int'(pick_idx)*DW +: DW];
        owner <= pick_idx;
        rr_ptr <= pick_idx;
        beats_left <= req_we[pick_idx] ? BW'(1) :
                      BW'(clamp_len(int'(req_len[int'(pick_idx)*BLW +: BLW]), MAX_BURST));
      end else if (!free) begin
        mem_addr <= mem_addr + AW'(1);
        beats_left <= beats_left - BW'(1);
        mem_we <= 1'b0;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        beats_left <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  localparam int NREQ = 3, AW = 32, DW = 32, MB = 4, BLW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, req_we = '0, gnt, rvalid;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ*BLW-1:0] req_len = '0;
  logic rlast, mem_en, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MB), .BLW(BLW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len), .gnt(gnt), .rvalid(rvalid), .rlast(rlast),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  // memory model: read data is the address plus 0x100, one cycle after the read strobe
  always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_addr + 32'h100;
  typedef struct { int own; logic [31:0] d; bit last; } beat_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  beat_t rq[$];
  wr_t wq[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int g = -100, n = 1, rr = NREQ - 1, j;
  bit g_we = 0, prev_rd = 0, en_exp, free;
  logic [NREQ-1:0] granted = '0, eg;
  always @(posedge clk) cyc++;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask
  // monitor and reference model: bus occupancy from grant time and length, round-robin from last winner
  always @(negedge clk) begin
    beat_t b;
    wr_t w;
    en_exp = cyc > g && cyc <= g + n;
    chk("mem_en", mem_en, en_exp);
    chk("mem_we", mem_we, en_exp && g_we);
    chk("busy", busy, en_exp || prev_rd);
    if (prev_rd) begin
      if (rq.size() == 0) begin
        n_chk++;
        $display("FAIL rvalid_unexpected @cyc %0d: got %0h expected none", cyc, rvalid);
      end else begin
        b = rq.pop_front();
        chk("rvalid", rvalid, 64'(1) << b.own);
        chk("rdata", rdata, b.d);
        chk("rlast", rlast, b.last);
      end
    end else chk("rvalid_idle", rvalid, 0);
    if (mem_en && mem_we) begin
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL write_unexpected @cyc %0d: got addr %0h expected none", cyc, mem_addr);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", mem_wdata, w.d);
      end
    end
    free = cyc >= g + n;
    eg = '0;
    if (free && !rst)
      for (int k = 1; k <= NREQ; k++) begin
        j = (rr + k) % NREQ;
        if (req[j] && eg == 0) eg[j] = 1'b1;
      end
    chk("gnt", gnt, eg);
    if (rst) begin
      rq.delete(); wq.delete();
      g = -100; n = 1; rr = NREQ - 1; prev_rd = 0;
    end else begin
      prev_rd = en_exp && !g_we;
      if (eg != 0) begin
        for (int k = 0; k < NREQ; k++) if (eg[k]) j = k;
        rr = j; g = cyc; g_we = req_we[j];
        if (g_we) begin
          n = 1;
          w.a = req_addr[j*AW +: AW]; w.d = req_wdata[j*DW +: DW];
          wq.push_back(w);
        end else begin
          n = req_len[j*BLW +: BLW] == 0 ? 1 : (req_len[j*BLW +: BLW] > MB ? MB : int'(req_len[j*BLW +: BLW]));
          for (int i = 0; i < n; i++) begin
            b.own = j; b.d = req_addr[j*AW +: AW] + 32'(i) + 32'h100; b.last = (i == n - 1);
            rq.push_back(b);
          end
        end
      end
    end
    granted = gnt;
  end
  task automatic set_req(int i, bit we, logic [31:0] a, logic [31:0] d, int len);
    req[i] = 1'b1; req_we[i] = we;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_len[i*BLW +: BLW] = BLW'(len);
  endtask
  task automatic step(int cnt = 1, bit rnd = 0);
    repeat (cnt) begin
      @(posedge clk); #1;
      req = req & ~granted;
      if (rnd)
        for (int i = 0; i < NREQ; i++)
          if (!req[i] && $urandom_range(0, 2) == 0)
            set_req(i, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0 ? 32'hFFFF_FFFE : $urandom(), $urandom(),
                    $urandom_range(0, 7));
    end
  endtask
  initial begin
    step(2);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rvalid", rvalid, 0);
    rst = 1'b0;
    set_req(REQ_FETCH, 0, 32'h10, 0, 3); step(6);
    set_req(REQ_FETCH, 0, 32'h100, 0, 1); set_req(REQ_WB, 0, 32'h200, 0, 1);
    set_req(REQ_LOAD, 0, 32'h300, 0, 1); step(5);
    set_req(REQ_FETCH, 0, 32'h400, 0, 1); step(3);
    set_req(REQ_FETCH, 0, 32'h500, 0, 1); set_req(REQ_WB, 0, 32'h600, 0, 1); step(5);
    set_req(REQ_FETCH, 0, 32'h20, 0, 4); step();
    set_req(REQ_WB, 1, 32'h5, 32'hDEAD_BEEF, 0); step(8);
    set_req(REQ_FETCH, 0, 32'h30, 0, 0); step(4);
    set_req(REQ_LOAD, 0, 32'h40, 0, 7); step(7);
    set_req(REQ_WB, 0, 32'hFFFF_FFFF, 0, 2); step(5);
    set_req(REQ_FETCH, 0, 32'h50, 0, 4); step(2);
    rst = 1'b1; step();
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rvalid", rvalid, 0);
    rst = 1'b0;
    set_req(REQ_LOAD, 0, 32'h60, 0, 1); set_req(REQ_FETCH, 0, 32'h70, 0, 1); step(5);
    step(10);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_busy", busy, 0);
    set_req(REQ_LOAD, 0, 32'h80, 0, 1); set_req(REQ_WB, 0, 32'h90, 0, 1); step(5);
    step(600, 1);
    req = '0; step(12);
    chk("drain_reads", rq.size(), 0);
    chk("drain_writes", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
